// File: rtl/shift_seq_ctrl.sv
// Shift-register sequencer: arbitrates two requesters round-robin and
// walks each job through CLEAR, LOAD, WIDTH SHIFT cycles and DONE.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   reqN_valid/data/ready       requester handshakes (ready = accept strobe)
//   sr_clr/load/shift_en/extend shift-register commands (registered)
//   sr_data_in                  latched word for the shift register
//   sr_q                        shift-register parallel output
//   busy, done, done_id, result job status and captured result
// Optional macro SHIFT_SEQ_ABORT_EN adds input abort / output aborted.
module shift_seq_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sr_clr,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic             sr_extend,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           ptr_q;
  logic           id_q;
  logic           gnt_any;
  logic           gnt_id;
  logic           accept;
  logic           abort_hit;
  logic [WIDTH-1:0] gnt_data;

  // Pointer names the favoured requester; it only matters on a tie.
  assign gnt_any  = req0_valid | req1_valid;
  assign gnt_id   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign gnt_data = gnt_id ? req1_data : req0_data;
  assign accept   = (state_q == S_IDLE) & gnt_any;

  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept &  gnt_id;
  assign sr_extend  = 1'b0;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort & ((state_q == S_CLEAR) |
                              (state_q == S_LOAD)  |
                              (state_q == S_SHIFT));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gnt_any) state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Job bookkeeping: word, owner and arbitration pointer move on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      sr_data_in <= '0;
    end else if (accept) begin
      ptr_q      <= ~gnt_id;
      id_q       <= gnt_id;
      sr_data_in <= gnt_data;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_clr      <= 1'b0;
      sr_load     <= 1'b0;
      sr_shift_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
    end else begin
      sr_clr      <= (state_d == S_CLEAR) | abort_hit;
      sr_load     <= (state_d == S_LOAD);
      sr_shift_en <= (state_d == S_SHIFT);
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_DONE);
      done_id     <= (state_d == S_DONE) ? id_q : 1'b0;
    end
  end

  // The last shift lands on the edge entering DONE, so sr_q is
  // only settled during DONE; capture it on the edge leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (state_q == S_DONE) begin
      result <= sr_q;
    end
  end

`ifdef SHIFT_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=5) with a rotating
// shift-register stand-in driving sr_q.
module tb_shift_seq_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         sr_clr;
  logic         sr_load;
  logic         sr_shift_en;
  logic         sr_extend;
  logic [W-1:0] sr_data_in;
  logic [W-1:0] sr_q = '0;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
  logic         abort = 1'b0;
  logic         aborted;
`endif

  int tests = 0;
  int fails = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sr_clr     (sr_clr),
    .sr_load    (sr_load),
    .sr_shift_en(sr_shift_en),
    .sr_extend  (sr_extend),
    .sr_data_in (sr_data_in),
    .sr_q       (sr_q),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .result     (result)
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  always #5 clk = ~clk;

  // Shift-register stand-in: clear, load, rotate left.
  always @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else if (sr_clr) sr_q <= '0;
    else if (sr_load) sr_q <= sr_data_in;
    else if (sr_shift_en) sr_q <= {sr_q[W-2:0], sr_q[W-1]};
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if ({sr_clr, sr_load, sr_shift_en, sr_extend, busy, done,
         done_id, req0_ready, req1_ready} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0",
               {sr_clr, sr_load, sr_shift_en, sr_extend, busy,
                done, done_id, req0_ready, req1_ready});
    end
    tests++;
    if (result !== '0 || sr_data_in !== '0) begin
      fails++;
      $display("FAIL reset_data result=%b data_in=%b want 0",
               result, sr_data_in);
    end
  endtask

  task automatic test_single();
    int n_clr = 0;
    int n_load = 0;
    int n_sh = 0;
    int done_at = -1;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 5'b10101;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_ready got %b%b want 10",
               req0_ready, req1_ready);
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    req0_data = 5'b00000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_clr += int'(sr_clr);
      n_load += int'(sr_load);
      n_sh += int'(sr_shift_en);
      if (done && done_at < 0) done_at = k;
      tests++;
      if (sr_clr !== (k == 1) || sr_load !== (k == 2) ||
          sr_shift_en !== (k >= 3 && k <= 7)) begin
        fails++;
        $display("FAIL single_seq k=%0d clr/load/sh=%b%b%b",
                 k, sr_clr, sr_load, sr_shift_en);
      end
      tests++;
      if (busy !== (k <= 8) || sr_data_in !== 5'b10101) begin
        fails++;
        $display("FAIL single_busy k=%0d busy=%b data_in=%b",
                 k, busy, sr_data_in);
      end
    end
    tests++;
    if (n_clr != 1 || n_load != 1 || n_sh != 5) begin
      fails++;
      $display("FAIL single_counts clr=%0d load=%0d sh=%0d want 1 1 5",
               n_clr, n_load, n_sh);
    end
    tests++;
    if (done_at != 8) begin
      fails++;
      $display("FAIL single_latency got %0d want 8", done_at);
    end
    tests++;
    if (result !== 5'b10101) begin
      fails++;
      $display("FAIL single_result got %b want 10101", result);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    do_reset();
    req0_valid = 1'b1;
    req0_data = 5'b00011;
    req1_valid = 1'b1;
    req1_data = 5'b11000;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL rr_first got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      #1;
      if (done) ids.push_back(int'(done_id));
      if (k == 9) begin
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
          fails++;
          $display("FAIL rr_second got %b%b want 01",
                   req0_ready, req1_ready);
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tests++;
    if (ids.size() != 2 || ids[0] != 0 || ids[1] != 1) begin
      fails++;
      $display("FAIL rr_done_ids got n=%0d want 0,1", ids.size());
    end
    @(negedge clk);
    tests++;
    if (result !== 5'b11000) begin
      fails++;
      $display("FAIL rr_result got %b want 11000", result);
    end
  endtask

  task automatic test_back_to_back();
    int rdy[$];
    int bad = 0;
    do_reset();
    req1_valid = 1'b1;
    req1_data = 5'b01101;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req1_ready) rdy.push_back(c);
      if (req0_ready) bad++;
      if (done && done_id !== 1'b1) bad++;
      @(negedge clk);
    end
    req1_valid = 1'b0;
    tests++;
    if (rdy.size() != 4) begin
      fails++;
      $display("FAIL b2b_count got %0d want 4", rdy.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rdy[i] != 9 * i) begin
          fails++;
          $display("FAIL b2b_accept%0d got %0d want %0d",
                   i, rdy[i], 9 * i);
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_grant_id got %0d bad want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1;
    req0_data = 5'b11011;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    tests++;
    if (sr_shift_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre shift_en got %b want 1", sr_shift_en);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({sr_clr, sr_load, sr_shift_en, busy, done, done_id} !== 6'b0 ||
        sr_data_in !== '0 || result !== '0) begin
      fails++;
      $display("FAIL mid_async ctrl=%b data_in=%b result=%b want 0",
               {sr_clr, sr_load, sr_shift_en, busy, done, done_id},
               sr_data_in, result);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_after k=%0d done=%b busy=%b want 0 0",
                 k, done, busy);
      end
    end
  endtask

  task automatic test_valid_drop();
    int seen = 0;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 5'b00111;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req1_valid = (k == 3 || k == 4);
      req1_data = 5'b11111;
      #1;
      if (req1_ready || req0_ready) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL drop_ready got %0d strobes want 0", seen);
    end
    tests++;
    if (sr_data_in !== 5'b00111 || result !== 5'b00111) begin
      fails++;
      $display("FAIL drop_data data_in=%b result=%b want 00111",
               sr_data_in, result);
    end
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    int n_done = 0;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 5'b10110;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    for (int k = 1; k <= 9; k++) @(negedge clk);
    req0_valid = 1'b1;
    req0_data = 5'b01001;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    tests++;
    if (sr_clr !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0 ||
        sr_load !== 1'b0 || sr_shift_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_next clr=%b aborted=%b busy=%b want 1 1 0",
               sr_clr, aborted, busy);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    tests++;
    if (n_done != 0 || result !== 5'b10110) begin
      fails++;
      $display("FAIL abort_after done=%0d result=%b want 0 10110",
               n_done, result);
    end
  endtask
`endif

  initial begin
    fork
      forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
          tests++;
          if (int'(sr_clr) + int'(sr_load) + int'(sr_shift_en) > 1 ||
              (busy && (req0_ready || req1_ready)) ||
              (req0_ready && req1_ready) || sr_extend !== 1'b0) begin
            fails++;
            $display("FAIL protocol clr/load/sh=%b%b%b busy=%b rdy=%b%b",
                     sr_clr, sr_load, sr_shift_en, busy,
                     req0_ready, req1_ready);
          end
        end
      end
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_valid_drop();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
